// File: rtl/active_pixel_loader.sv
// Write-side loader for the double-buffered active-pixel mask memory: serialises
// 32-bit mask words LSB-first into per-pixel writes and flips banks on frame swap.
module active_pixel_loader #(
   parameter int WORD_W = 32,
   parameter int DEPTH  = 512,
   parameter int ADDR_W = 9
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [WORD_W-1:0] s_data_i,
   input  logic              s_valid_i,
   output logic              s_ready_o,
   input  logic              swap_i,
   output logic [ADDR_W-1:0] waddr_o,
   output logic              wdata_o,
   output logic              wen_o,
   output logic              mem_selector_o,
   output logic              buf_full_o,
   output logic              swap_miss_o
);

   localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

   state_t            state_q, state_d;
   logic [WORD_W-1:0] sreg_q, sreg_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d, waddr_d;
   logic              wdata_d, wen_d, sel_d, full_d, miss_d;
   logic              swap_ok;
   logic              ptr_last;

   assign s_ready_o = (state_q == IDLE);
   assign ptr_last  = (ptr_q == ADDR_W'(DEPTH - 1));
   // A swap only counts once buf_full_o is visible, so one coincident with the last write is a miss.
   assign swap_ok   = swap_i && (state_q == FULL) && buf_full_o;

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      waddr_d = waddr_o;
      wdata_d = wdata_o;
      wen_d   = 1'b0;
      sel_d   = mem_selector_o;
      full_d  = buf_full_o;
      miss_d  = swap_i && !swap_ok;
      case (state_q)
         IDLE: begin
            if (s_valid_i) begin
               sreg_d  = s_data_i;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            wen_d   = 1'b1;
            wdata_d = sreg_q[0];
            waddr_d = ptr_q;
            sreg_d  = sreg_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            ptr_d   = ptr_last ? '0 : ptr_q + 1'b1;
            if (cnt_q == CNT_W'(WORD_W - 1)) begin
               state_d = ptr_last ? FULL : IDLE;
            end
         end
         FULL: begin
            if (swap_ok) begin
               sel_d   = ~mem_selector_o;
               full_d  = 1'b0;
               state_d = IDLE;
            end else begin
               full_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q        <= IDLE;
         sreg_q         <= '0;
         cnt_q          <= '0;
         ptr_q          <= '0;
         waddr_o        <= '0;
         wdata_o        <= 1'b0;
         wen_o          <= 1'b0;
         mem_selector_o <= 1'b0;
         buf_full_o     <= 1'b0;
         swap_miss_o    <= 1'b0;
      end else begin
         state_q        <= state_d;
         sreg_q         <= sreg_d;
         cnt_q          <= cnt_d;
         ptr_q          <= ptr_d;
         waddr_o        <= waddr_d;
         wdata_o        <= wdata_d;
         wen_o          <= wen_d;
         mem_selector_o <= sel_d;
         buf_full_o     <= full_d;
         swap_miss_o    <= miss_d;
      end
   end

endmodule

// File: tb/tb_active_pixel_loader.sv
// Bench for active_pixel_loader: a pixel-count reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_active_pixel_loader;

   localparam int WORD_W = 32;
   localparam int DEPTH  = 512;
   localparam int ADDR_W = 9;

   logic              clk, rst_n;
   logic [WORD_W-1:0] s_data;
   logic              s_valid, s_ready, swap;
   logic [ADDR_W-1:0] waddr;
   logic              wdata, wen, mem_sel, buf_full, swap_miss;

   active_pixel_loader #(.WORD_W(WORD_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .s_data_i(s_data), .s_valid_i(s_valid),
      .s_ready_o(s_ready), .swap_i(swap), .waddr_o(waddr), .wdata_o(wdata),
      .wen_o(wen), .mem_selector_o(mem_sel), .buf_full_o(buf_full),
      .swap_miss_o(swap_miss)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: tracks pixels written into the current bank and bits left of the word in flight.
   int                m_bits_left = 0;
   int                m_filled    = 0;
   logic [WORD_W-1:0] m_word      = '0;
   logic              m_sel = 1'b0, m_full = 1'b0, m_wen = 1'b0, m_wdata = 1'b0, m_miss = 1'b0;
   logic [ADDR_W-1:0] m_addr = '0;
   int                hs_count = 0;
   logic              m_bank_full, m_ready, m_accept;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_bits_left = 0;
         m_filled    = 0;
         m_sel       = 1'b0;
         m_full      = 1'b0;
         m_wen       = 1'b0;
         m_wdata     = 1'b0;
         m_miss      = 1'b0;
         m_addr      = '0;
      end else begin
         m_bank_full = (m_filled == DEPTH);
         m_ready     = (m_bits_left == 0) && !m_bank_full;
         m_accept    = m_bank_full && m_full && swap;
         m_miss      = swap && !m_accept;
         m_full      = m_bank_full && !m_accept;
         if (m_bits_left > 0) begin
            m_wen   = 1'b1;
            m_addr  = ADDR_W'(m_filled);
            m_wdata = m_word[WORD_W - m_bits_left];
            m_filled++;
            m_bits_left--;
         end else begin
            m_wen = 1'b0;
         end
         if (m_accept) begin
            m_sel    = ~m_sel;
            m_filled = 0;
         end
         if (m_ready && s_valid) begin
            m_word      = s_data;
            m_bits_left = WORD_W;
            hs_count++;
         end
      end
   end

   // Compare process plus counters used by the directed literal checks.
   int   ncyc = 0, wen_count = 0, one_count = 0, one_bad = 0, miss_count = 0;
   int   cyc_last_wen = 0, cyc_full_rise = 0;
   int   last_addr = 0;
   int   addr_log [4096];
   logic prev_full = 1'b0;

   always @(negedge clk) begin
      ncyc++;
      chk("s_ready", 32'(s_ready), 32'((m_bits_left == 0) && (m_filled != DEPTH)));
      chk("wen", 32'(wen), 32'(m_wen));
      chk("buf_full", 32'(buf_full), 32'(m_full));
      chk("mem_selector", 32'(mem_sel), 32'(m_sel));
      chk("swap_miss", 32'(swap_miss), 32'(m_miss));
      if (m_wen) begin
         chk("waddr", 32'(waddr), 32'(m_addr));
         chk("wdata", 32'(wdata), 32'(m_wdata));
      end else if (!rst_n) begin
         chk("rst_waddr", 32'(waddr), 32'd0);
         chk("rst_wdata", 32'(wdata), 32'd0);
      end
      if (wen) begin
         addr_log[wen_count % 4096] = int'(waddr);
         wen_count++;
         last_addr    = int'(waddr);
         cyc_last_wen = ncyc;
         if (wdata) begin
            one_count++;
            if (waddr[4:0] != 5'd0) one_bad++;
         end
      end
      if (buf_full && !prev_full) cyc_full_rise = ncyc;
      prev_full = buf_full;
      if (swap_miss) miss_count++;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   int   b_wen, b_one, b_bad, b_hs, b_miss;
   logic ok;

   initial begin
      rst_n = 1'b0; s_valid = 1'b0; s_data = '0; swap = 1'b0;
      repeat (3) tick();
      #1;
      chk("reset_ready", 32'(s_ready), 32'd1);
      chk("reset_wen", 32'(wen), 32'd0);
      chk("reset_waddr", 32'(waddr), 32'd0);
      chk("reset_sel", 32'(mem_sel), 32'd0);
      chk("reset_full", 32'(buf_full), 32'd0);
      chk("reset_miss", 32'(swap_miss), 32'd0);

      // Buffer of sixteen 0x00000001 words, valid held high.
      s_data = 32'h0000_0001; s_valid = 1'b1;
      tick();
      rst_n = 1'b1;
      b_wen = wen_count; b_one = one_count; b_bad = one_bad; b_hs = hs_count;
      ok = 1'b0;
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         if (buf_full) begin ok = 1'b1; break; end
      end
      chk("a_full_reached", 32'(ok), 32'd1);
      #1;
      chk("a_wen_count", 32'(wen_count - b_wen), 32'd512);
      chk("a_ones", 32'(one_count - b_one), 32'd16);
      chk("a_ones_misplaced", 32'(one_bad - b_bad), 32'd0);
      chk("a_first_addr", 32'(addr_log[b_wen % 4096]), 32'd0);
      chk("a_last_addr", 32'(last_addr), 32'd511);
      chk("a_full_lag", 32'(cyc_full_rise - cyc_last_wen), 32'd1);
      chk("a_handshakes", 32'(hs_count - b_hs), 32'd16);
      chk("a_sel", 32'(mem_sel), 32'd0);
      tick();
      s_valid = 1'b0;
      tick(); swap = 1'b1;
      tick(); swap = 1'b0;
      #1;
      chk("a_swap_sel", 32'(mem_sel), 32'd1);
      chk("a_swap_full", 32'(buf_full), 32'd0);
      chk("a_swap_ready", 32'(s_ready), 32'd1);

      // Second buffer with 0xA5A5A5A5 held valid, early swap after five words.
      b_wen = wen_count; b_hs = hs_count; b_miss = miss_count;
      s_data = 32'hA5A5_A5A5; s_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (wen_count - b_wen >= 160) begin ok = 1'b1; break; end
      end
      chk("b_five_words", 32'(ok), 32'd1);
      tick(); swap = 1'b1;
      tick(); swap = 1'b0;
      #1;
      chk("b_miss_pulse", 32'(swap_miss), 32'd1);
      chk("b_miss_sel", 32'(mem_sel), 32'd1);
      tick();
      #1;
      chk("b_miss_one_cycle", 32'(swap_miss), 32'd0);
      ok = 1'b0;
      for (int i = 0; i < 700; i++) begin
         @(negedge clk);
         if (buf_full) begin ok = 1'b1; break; end
      end
      chk("b_full_reached", 32'(ok), 32'd1);
      #1;
      chk("b_wen_count", 32'(wen_count - b_wen), 32'd512);
      chk("b_handshakes", 32'(hs_count - b_hs), 32'd16);
      chk("b_first_addr", 32'(addr_log[b_wen % 4096]), 32'd0);
      chk("b_addr_160", 32'(addr_log[(b_wen + 160) % 4096]), 32'd160);
      chk("b_last_addr", 32'(last_addr), 32'd511);
      chk("b_miss_count", 32'(miss_count - b_miss), 32'd1);
      chk("b_sel", 32'(mem_sel), 32'd1);
      repeat (10) tick();
      #1;
      chk("b_hold_wen_count", 32'(wen_count - b_wen), 32'd512);
      chk("b_hold_handshakes", 32'(hs_count - b_hs), 32'd16);
      chk("b_hold_ready", 32'(s_ready), 32'd0);

      // Third buffer: swap lands in the same cycle as the write to address 511.
      b_wen = wen_count;
      tick(); swap = 1'b1;
      tick(); swap = 1'b0;
      #1;
      chk("d_swap_sel", 32'(mem_sel), 32'd0);
      ok = 1'b0;
      for (int i = 0; i < 700; i++) begin
         @(negedge clk);
         if (wen && waddr == 9'd511) begin ok = 1'b1; break; end
      end
      chk("d_reached_511", 32'(ok), 32'd1);
      swap = 1'b1;
      @(posedge clk);
      #2;
      swap = 1'b0;
      #1;
      chk("d_coincident_miss", 32'(swap_miss), 32'd1);
      chk("d_coincident_full", 32'(buf_full), 32'd1);
      chk("d_coincident_sel", 32'(mem_sel), 32'd0);
      chk("d_wen_count", 32'(wen_count - b_wen), 32'd512);
      tick();
      #1;
      chk("d_miss_cleared", 32'(swap_miss), 32'd0);
      chk("d_still_full", 32'(buf_full), 32'd1);
      chk("d_still_sel", 32'(mem_sel), 32'd0);
      chk("d_not_ready", 32'(s_ready), 32'd0);
      tick(); swap = 1'b1;
      tick(); swap = 1'b0;
      #1;
      chk("d_late_swap_sel", 32'(mem_sel), 32'd1);
      chk("d_late_swap_full", 32'(buf_full), 32'd0);

      // Reset in the middle of a word, at address 77.
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (wen && waddr == 9'd77) begin ok = 1'b1; break; end
      end
      chk("e_reached_77", 32'(ok), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("e_async_wen", 32'(wen), 32'd0);
      chk("e_async_waddr", 32'(waddr), 32'd0);
      chk("e_async_sel", 32'(mem_sel), 32'd0);
      chk("e_async_full", 32'(buf_full), 32'd0);
      chk("e_async_ready", 32'(s_ready), 32'd1);
      tick(); tick();
      rst_n = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (wen) begin ok = 1'b1; break; end
      end
      chk("e_restart_seen", 32'(ok), 32'd1);
      chk("e_restart_addr", 32'(waddr), 32'd0);

      // Randomized traffic with occasional swaps and resets.
      for (int i = 0; i < 4000; i++) begin
         tick();
         s_valid = ($urandom_range(3) != 0);
         s_data  = $urandom;
         swap    = ($urandom_range(39) == 0);
         if (!rst_n) rst_n = 1'b1;
         else if ($urandom_range(1499) == 0) rst_n = 1'b0;
      end
      tick();
      rst_n = 1'b1; s_valid = 1'b0; swap = 1'b0;
      repeat (5) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
